// File: rtl/block_data_memory.sv
// Block-granular backing memory behind the set-associative cache.
// Serves whole-block refills and write-backs with a fixed multi-cycle
// latency, signalled through a busywait/done handshake.
module block_data_memory #(
    parameter int unsigned BLOCK_WIDTH   = 128,
    parameter int unsigned ADDR_WIDTH    = 28,
    parameter int unsigned DEPTH_LOG2    = 8,
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   m_read_i,
    input  logic                   m_wr_i,
    input  logic [ADDR_WIDTH-1:0]  m_address_i,
    input  logic [BLOCK_WIDTH-1:0] m_write_data_i,
    output logic                   m_busywait_o,
    output logic [BLOCK_WIDTH-1:0] m_read_data_o,
    output logic                   m_read_done_o,
    output logic                   m_write_done_o
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY
                                                                     : WRITE_LATENCY;
    localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BUSY_RD = 3'd1,
        S_BUSY_WR = 3'd2,
        S_DONE_RD = 3'd3,
        S_DONE_WR = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
    logic [BLOCK_WIDTH-1:0] wdata_q, wdata_d;

    logic                   busywait_q, busywait_d;
    logic                   read_done_q, read_done_d;
    logic                   write_done_q, write_done_d;
    logic [BLOCK_WIDTH-1:0] read_data_q;

    logic                   mem_we_c;
    logic                   rd_load_c;

    logic [BLOCK_WIDTH-1:0] mem_q [DEPTH];

    // Address bits above the index only alias; they carry no storage meaning.
    logic                   unused_addr_hi;
    assign unused_addr_hi = ^m_address_i[ADDR_WIDTH-1:DEPTH_LOG2];

    // Next-state, request latching, and registered-output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        mem_we_c     = 1'b0;
        rd_load_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Write has priority; a concurrent read is dropped, not queued.
                if (m_wr_i) begin
                    state_d = S_BUSY_WR;
                    cnt_d   = CNT_W'(WRITE_LATENCY - 1);
                    idx_d   = m_address_i[DEPTH_LOG2-1:0];
                    wdata_d = m_write_data_i;
                end else if (m_read_i) begin
                    state_d = S_BUSY_RD;
                    cnt_d   = CNT_W'(READ_LATENCY - 1);
                    idx_d   = m_address_i[DEPTH_LOG2-1:0];
                end
            end
            S_BUSY_RD: begin
                if (cnt_q == '0) begin
                    state_d   = S_DONE_RD;
                    rd_load_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_BUSY_WR: begin
                if (cnt_q == '0) begin
                    state_d  = S_DONE_WR;
                    mem_we_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE_RD,
            S_DONE_WR: begin
                // Requests seen here are ignored; a new one is sampled only in IDLE.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busywait_d   = (state_d == S_BUSY_RD) || (state_d == S_BUSY_WR);
        read_done_d  = (state_d == S_DONE_RD);
        write_done_d = (state_d == S_DONE_WR);
    end

    // Control state, latched request and output flags.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
            busywait_q   <= 1'b0;
            read_done_q  <= 1'b0;
            write_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            busywait_q   <= busywait_d;
            read_done_q  <= read_done_d;
            write_done_q <= write_done_d;
        end
    end

    // Block storage; reset clears every block, commit happens on entry to DONE_WR.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we_c) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    // Refill data register; holds its value outside DONE_RD.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            read_data_q <= '0;
        end else if (rd_load_c) begin
            read_data_q <= mem_q[idx_q];
        end
    end

    assign m_busywait_o   = busywait_q;
    assign m_read_done_o  = read_done_q;
    assign m_write_done_o = write_done_q;
    assign m_read_data_o  = read_data_q;

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory: vector table plus corner-case sequences.
module tb_block_data_memory;

    localparam int unsigned BW  = 128;
    localparam int unsigned AW  = 28;
    localparam int unsigned LAT = 4;

    logic          clk;
    logic          reset_i;
    logic          m_read_i;
    logic          m_wr_i;
    logic [AW-1:0] m_address_i;
    logic [BW-1:0] m_write_data_i;
    logic          m_busywait_o;
    logic [BW-1:0] m_read_data_o;
    logic          m_read_done_o;
    logic          m_write_done_o;

    int            total;
    int            passed;
    logic [BW-1:0] last_rd;

    block_data_memory dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .m_read_i       (m_read_i),
        .m_wr_i         (m_wr_i),
        .m_address_i    (m_address_i),
        .m_write_data_i (m_write_data_i),
        .m_busywait_o   (m_busywait_o),
        .m_read_data_o  (m_read_data_o),
        .m_read_done_o  (m_read_done_o),
        .m_write_done_o (m_write_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
        logic [BW-1:0] exp;
    } vec_t;

    localparam logic [BW-1:0] DA = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [BW-1:0] DB = 128'hDEADBEEFCAFEF00D123456789ABCDEF0;
    localparam logic [BW-1:0] DC = 128'hFEDCBA98765432100F1E2D3C4B5A6978;
    localparam logic [BW-1:0] DD = 128'h11112222333344445555666677778888;
    localparam logic [BW-1:0] DX = {16{8'hAA}};

    vec_t vecs [11];

    function automatic logic [2:0] st();
        return {m_busywait_o, m_read_done_o, m_write_done_o};
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // One full access: request held for the sample edge only, inputs scrambled afterwards.
    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [AW-1:0] addr, input logic [BW-1:0] data,
                              input logic [BW-1:0] exp);
        @(negedge clk);
        m_read_i       = rd;
        m_wr_i         = wr;
        m_address_i    = addr;
        m_write_data_i = data;
        @(posedge clk);
        @(negedge clk);
        m_read_i       = 1'b0;
        m_wr_i         = 1'b0;
        m_address_i    = ~addr;
        m_write_data_i = ~data;
        check({name, " busy c0"}, 128'(st()), 128'(3'b100));
        for (int k = 1; k < LAT; k++) begin
            @(negedge clk);
            check({name, " busy"}, 128'(st()), 128'(3'b100));
        end
        @(negedge clk);
        if (wr) begin
            check({name, " wr_done"}, 128'(st()), 128'(3'b001));
            check({name, " rdata held"}, m_read_data_o, last_rd);
        end else begin
            check({name, " rd_done"}, 128'(st()), 128'(3'b010));
            check({name, " rdata"}, m_read_data_o, exp);
            last_rd = exp;
        end
        @(negedge clk);
        check({name, " idle"}, 128'(st()), 128'(3'b000));
        check({name, " rdata hold"}, m_read_data_o, last_rd);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        total          = 0;
        passed         = 0;
        last_rd        = '0;
        reset_i        = 1'b1;
        m_read_i       = 1'b0;
        m_wr_i         = 1'b0;
        m_address_i    = '0;
        m_write_data_i = '0;

        vecs[0]  = '{"rd 05 clear",   1'b1, 1'b0, 28'h0000005, '0, '0};
        vecs[1]  = '{"wr 10",         1'b0, 1'b1, 28'h0000010, DA, '0};
        vecs[2]  = '{"rd 10",         1'b1, 1'b0, 28'h0000010, '0, DA};
        vecs[3]  = '{"wr 000",        1'b0, 1'b1, 28'h0000000, DX, '0};
        vecs[4]  = '{"rd 100 alias",  1'b1, 1'b0, 28'h0000100, '0, DX};
        vecs[5]  = '{"rd+wr 20",      1'b1, 1'b1, 28'h0000020, DB, '0};
        vecs[6]  = '{"rd 20",         1'b1, 1'b0, 28'h0000020, '0, DB};
        vecs[7]  = '{"rd 120 alias",  1'b1, 1'b0, 28'h0000120, '0, DB};
        vecs[8]  = '{"wr fffffff",    1'b0, 1'b1, 28'hFFFFFFF, DC, '0};
        vecs[9]  = '{"rd 0ff",        1'b1, 1'b0, 28'h00000FF, '0, DC};
        vecs[10] = '{"rd 01 clear",   1'b1, 1'b0, 28'h0000001, '0, '0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset status", 128'(st()), 128'(3'b000));
        check("reset rdata", m_read_data_o, '0);
        reset_i = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_access(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].addr,
                       vecs[i].data, vecs[i].exp);
        end

        // Reset during a write at busy cycle 2: abort, no commit, no done.
        @(negedge clk);
        m_wr_i         = 1'b1;
        m_address_i    = 28'h0000030;
        m_write_data_i = DD;
        @(posedge clk);
        @(negedge clk);
        m_wr_i = 1'b0;
        check("abort busy c0", 128'(st()), 128'(3'b100));
        @(negedge clk);
        check("abort busy c1", 128'(st()), 128'(3'b100));
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        check("abort reset status", 128'(st()), 128'(3'b000));
        check("abort reset rdata", m_read_data_o, '0);
        last_rd = '0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            check("abort no done", 128'(st()), 128'(3'b000));
        end
        run_access("rd 30 after abort", 1'b1, 1'b0, 28'h0000030, '0, '0);
        run_access("rd 10 wiped", 1'b1, 1'b0, 28'h0000010, '0, '0);

        // Read with request dropped and address changed mid-access, then held through done.
        run_access("wr 10 again", 1'b0, 1'b1, 28'h0000010, DD, '0);
        run_access("wr 55", 1'b0, 1'b1, 28'h0000055, DC, '0);
        @(negedge clk);
        m_read_i    = 1'b1;
        m_address_i = 28'h0000010;
        @(posedge clk);
        @(negedge clk);
        m_read_i    = 1'b0;
        m_address_i = 28'h0000055;
        check("hold busy c0", 128'(st()), 128'(3'b100));
        @(negedge clk);
        m_read_i = 1'b1;
        check("hold busy c1", 128'(st()), 128'(3'b100));
        for (int k = 2; k < LAT; k++) begin
            @(negedge clk);
            check("hold busy", 128'(st()), 128'(3'b100));
        end
        @(negedge clk);
        check("hold rd_done", 128'(st()), 128'(3'b010));
        check("hold rdata latched addr", m_read_data_o, DD);
        @(negedge clk);
        check("hold no restart", 128'(st()), 128'(3'b000));
        m_read_i = 1'b0;
        for (int k = 0; k < LAT + 1; k++) begin
            @(negedge clk);
            check("hold quiet", 128'(st()), 128'(3'b000));
        end
        check("hold rdata kept", m_read_data_o, DD);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
